// File: rtl/tone_sequencer.sv
// Purpose: steps through a programmable note table and drives period/load/enable to the tone counter.
// Latency: start sampled at edge k -> busy at k; first load_o/tone_en_o after edge k+1; all outputs registered.
// Backpressure: none; table writes accepted every cycle, stop_i aborts playback on the next edge.
module tone_sequencer #(
    parameter int STEPS     = 8,
    parameter int PW        = 8,
    parameter int DW        = 4,
    parameter int TICK_DIV  = 1000,
    parameter int GAP_TICKS = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(STEPS)-1:0] wr_addr_i,
    input  logic [PW-1:0]            wr_period_i,
    input  logic [DW-1:0]            wr_dur_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     loop_i,
    output logic                     busy_o,
    output logic [$clog2(STEPS)-1:0] step_o,
    output logic [PW-1:0]            period_o,
    output logic                     load_o,
    output logic                     tone_en_o,
    output logic                     done_o
);
    localparam int AW  = $clog2(STEPS);
    localparam int PSW = $clog2(TICK_DIV);
    localparam int GW  = $clog2(GAP_TICKS + 1);
    // The tick counter is shared by note duration and gap length, so size it for the larger.
    localparam int CW  = (DW > GW) ? DW : GW;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, END} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   period_tab [STEPS];
    logic [DW-1:0]   dur_tab    [STEPS];
    logic [PSW-1:0]  presc, presc_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [AW-1:0]   step_nxt;
    logic [PW-1:0]   period_nxt;
    logic            load_nxt, tone_nxt, done_nxt;
    logic            tick;

    assign tick   = (presc == PSW'(TICK_DIV - 1));
    assign busy_o = (state != IDLE);

    // Note table: written any time, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < STEPS; i++) begin
                period_tab[i] <= '0;
                dur_tab[i]    <= '0;
            end
        end else if (wr_en_i) begin
            period_tab[wr_addr_i] <= wr_period_i;
            dur_tab[wr_addr_i]    <= wr_dur_i;
        end
    end

    // Next-state and next-output logic; stop overrides everything else.
    always_comb begin
        state_nxt  = state;
        step_nxt   = step_o;
        period_nxt = period_o;
        load_nxt   = 1'b0;
        tone_nxt   = tone_en_o;
        done_nxt   = 1'b0;
        cnt_nxt    = cnt;
        presc_nxt  = presc;
        if (state != IDLE && stop_i) begin
            state_nxt = IDLE;
            tone_nxt  = 1'b0;
            step_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state_nxt = LOAD;
                        step_nxt  = '0;
                    end
                end
                LOAD: begin
                    // Zero duration marks the end of the program.
                    if (dur_tab[step_o] == '0) begin
                        state_nxt = END;
                    end else begin
                        period_nxt = period_tab[step_o];
                        load_nxt   = 1'b1;
                        tone_nxt   = |period_tab[step_o];
                        cnt_nxt    = CW'(dur_tab[step_o]);
                        presc_nxt  = '0;
                        state_nxt  = PLAY;
                    end
                end
                PLAY, GAP: begin
                    presc_nxt = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        cnt_nxt = cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            tone_nxt = 1'b0;
                            if (state == PLAY && GAP_TICKS > 0) begin
                                state_nxt = GAP;
                                cnt_nxt   = CW'(GAP_TICKS);
                                presc_nxt = '0;
                            end else if (step_o == AW'(STEPS - 1)) begin
                                state_nxt = END;
                            end else begin
                                step_nxt  = step_o + 1'b1;
                                state_nxt = LOAD;
                            end
                        end
                    end
                end
                END: begin
                    tone_nxt = 1'b0;
                    step_nxt = '0;
                    if (loop_i) begin
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            step_o    <= '0;
            period_o  <= '0;
            load_o    <= 1'b0;
            tone_en_o <= 1'b0;
            done_o    <= 1'b0;
            cnt       <= '0;
            presc     <= '0;
        end else begin
            state     <= state_nxt;
            step_o    <= step_nxt;
            period_o  <= period_nxt;
            load_o    <= load_nxt;
            tone_en_o <= tone_nxt;
            done_o    <= done_nxt;
            cnt       <= cnt_nxt;
            presc     <= presc_nxt;
        end
    end
endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;
    localparam int STEPS = 8;
    localparam int PW    = 8;
    localparam int DW    = 4;
    localparam int TD    = 4;
    localparam int GAP   = 1;

    typedef struct packed {
        logic          busy;
        logic [2:0]    step;
        logic [PW-1:0] period;
        logic          load;
        logic          tone;
        logic          done;
    } obs_t;

    typedef struct {
        int   n;
        logic start;
        logic stop;
        logic loop;
        obs_t exp;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [2:0]    wr_addr_i = '0;
    logic [PW-1:0] wr_period_i = '0;
    logic [DW-1:0] wr_dur_i = '0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          loop_i = 1'b0;
    logic          busy_o;
    logic [2:0]    step_o;
    logic [PW-1:0] period_o;
    logic          load_o;
    logic          tone_en_o;
    logic          done_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int load_cnt = 0;
    logic [PW-1:0] mperiod;

    tone_sequencer #(
        .STEPS(STEPS), .PW(PW), .DW(DW), .TICK_DIV(TD), .GAP_TICKS(GAP)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_period_i(wr_period_i), .wr_dur_i(wr_dur_i), .start_i(start_i),
        .stop_i(stop_i), .loop_i(loop_i), .busy_o(busy_o), .step_o(step_o),
        .period_o(period_o), .load_o(load_o), .tone_en_o(tone_en_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (done_o) done_cnt++;
        if (load_o) load_cnt++;
    end

    function automatic obs_t cur();
        return '{busy_o, step_o, period_o, load_o, tone_en_o, done_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input obs_t e);
        obs_t a;
        a = cur();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got busy=%b step=%0d per=%0d load=%b tone=%b done=%b want busy=%b step=%0d per=%0d load=%b tone=%b done=%b",
                     name, cyc, a.busy, a.step, a.period, a.load, a.tone, a.done,
                     e.busy, e.step, e.period, e.load, e.tone, e.done);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wr(input int a, input int p, input int d);
        wr_en_i     = 1'b1;
        wr_addr_i   = 3'(a);
        wr_period_i = PW'(p);
        wr_dur_i    = DW'(d);
        tick();
        wr_en_i     = 1'b0;
    endtask

    // Timeline model: entry i starts LOAD at L_i, plays dur*TD cycles after it,
    // then GAP*TD silent cycles; a zero duration or running past the last entry ends it.
    task automatic run_random(input int it);
        logic [PW-1:0] p [STEPS];
        logic [DW-1:0] d [STEPS];
        obs_t ex [$];
        obs_t o;
        int ended;
        for (int i = 0; i < STEPS; i++) begin
            p[i] = PW'($urandom_range(0, 255));
            if (it == 0)          d[i] = 4'd1;
            else if (it % 3 == 1) d[i] = DW'($urandom_range(1, 3));
            else                  d[i] = DW'($urandom_range(0, 3));
            if (it % 4 == 3 && i == 2) p[i] = '0;
            wr(i, int'(p[i]), int'(d[i]));
        end
        ended = 0;
        for (int i = 0; i < STEPS && ended == 0; i++) begin
            o = '{1'b1, 3'(i), mperiod, 1'b0, 1'b0, 1'b0};
            ex.push_back(o);
            if (d[i] == 0) begin
                ex.push_back(o);
                ended = 1;
            end else begin
                mperiod = p[i];
                for (int k = 1; k <= (int'(d[i]) + GAP) * TD; k++) begin
                    o.period = mperiod;
                    o.load   = (k == 1);
                    o.tone   = (k <= int'(d[i]) * TD) && (p[i] != 0);
                    ex.push_back(o);
                end
            end
        end
        if (ended == 0) ex.push_back('{1'b1, 3'd7, mperiod, 1'b0, 1'b0, 1'b0});
        ex.push_back('{1'b0, 3'd0, mperiod, 1'b0, 1'b0, 1'b1});
        ex.push_back('{1'b0, 3'd0, mperiod, 1'b0, 1'b0, 1'b0});
        loop_i  = 1'b0;
        start_i = 1'b1;
        foreach (ex[j]) begin
            tick();
            start_i = 1'b0;
            chk("rand", ex[j]);
        end
    endtask

    initial begin
        vec_t vt [11];
        int dc0, lc0;
        vt[0]  = '{1, 1'b1, 1'b0, 1'b0, '{1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0}};
        vt[1]  = '{1, 1'b0, 1'b0, 1'b0, '{1'b1, 3'd0, 8'd5, 1'b1, 1'b1, 1'b0}};
        vt[2]  = '{7, 1'b0, 1'b0, 1'b0, '{1'b1, 3'd0, 8'd5, 1'b0, 1'b1, 1'b0}};
        vt[3]  = '{4, 1'b0, 1'b0, 1'b0, '{1'b1, 3'd0, 8'd5, 1'b0, 1'b0, 1'b0}};
        vt[4]  = '{1, 1'b0, 1'b0, 1'b0, '{1'b1, 3'd1, 8'd5, 1'b0, 1'b0, 1'b0}};
        vt[5]  = '{1, 1'b0, 1'b0, 1'b0, '{1'b1, 3'd1, 8'd0, 1'b1, 1'b0, 1'b0}};
        vt[6]  = '{7, 1'b0, 1'b0, 1'b0, '{1'b1, 3'd1, 8'd0, 1'b0, 1'b0, 1'b0}};
        vt[7]  = '{1, 1'b0, 1'b0, 1'b0, '{1'b1, 3'd2, 8'd0, 1'b0, 1'b0, 1'b0}};
        vt[8]  = '{1, 1'b0, 1'b0, 1'b0, '{1'b1, 3'd2, 8'd0, 1'b0, 1'b0, 1'b0}};
        vt[9]  = '{1, 1'b0, 1'b0, 1'b0, '{1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1}};
        vt[10] = '{2, 1'b0, 1'b0, 1'b0, '{1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0}};

        // Reset state
        tick();
        chk("reset", '{1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        rst_i = 1'b1;
        tick();
        chk("post_reset", '{1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0});

        // Basic program: note, rest, end marker
        wr(0, 5, 2);
        wr(1, 0, 1);
        wr(2, 0, 0);
        foreach (vt[r]) begin
            for (int k = 0; k < vt[r].n; k++) begin
                start_i = vt[r].start;
                stop_i  = vt[r].stop;
                loop_i  = vt[r].loop;
                tick();
                chk($sformatf("vec%0d", r), vt[r].exp);
            end
        end
        start_i = 1'b0;

        // Looping playback, then rewrite entry 0 while it plays
        dc0 = done_cnt;
        loop_i  = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("loop_c0", '{1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        repeat (24) tick();
        chk("loop_relOAD", '{1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        tick();
        chk("loop_refire", '{1'b1, 3'd0, 8'd5, 1'b1, 1'b1, 1'b0});
        wr(0, 9, 2);
        repeat (6) tick();
        chk("rewrite_hold", '{1'b1, 3'd0, 8'd5, 1'b0, 1'b1, 1'b0});
        repeat (16) tick();
        chk("loop2_load", '{1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        tick();
        chk("rewrite_new", '{1'b1, 3'd0, 8'd9, 1'b1, 1'b1, 1'b0});

        // Stop together with start mid-PLAY
        repeat (2) tick();
        stop_i  = 1'b1;
        start_i = 1'b1;
        tick();
        stop_i  = 1'b0;
        start_i = 1'b0;
        loop_i  = 1'b0;
        chk("stop", '{1'b0, 3'd0, 8'd9, 1'b0, 1'b0, 1'b0});
        tick();
        chk("stop_idle", '{1'b0, 3'd0, 8'd9, 1'b0, 1'b0, 1'b0});
        chk_int("no_done_loop_stop", done_cnt - dc0, 0);

        // Restart from step 0, then async reset mid-GAP
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart_c0", '{1'b1, 3'd0, 8'd9, 1'b0, 1'b0, 1'b0});
        tick();
        chk("restart_c1", '{1'b1, 3'd0, 8'd9, 1'b1, 1'b1, 1'b0});
        repeat (9) tick();
        chk("in_gap", '{1'b1, 3'd0, 8'd9, 1'b0, 1'b0, 1'b0});
        #3;
        rst_i = 1'b0;
        #1;
        chk("async_reset", '{1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        tick();
        chk("reset_hold", '{1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        rst_i = 1'b1;

        // Empty table: immediate END, done pulse, no load
        dc0 = done_cnt;
        lc0 = load_cnt;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("empty_load", '{1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        tick();
        chk("empty_end", '{1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        tick();
        chk("empty_done", '{1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1});
        tick();
        chk("empty_idle", '{1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        chk_int("empty_no_load", load_cnt - lc0, 0);
        chk_int("empty_one_done", done_cnt - dc0, 1);

        // Randomized programs against the timeline model
        mperiod = '0;
        for (int it = 0; it < 20; it++) run_random(it);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
